pdm_mic_capture: RTL and testbench

PDM_MIC_CAPTURE -- requirements
Module: pdm_mic_capture

---
 rtl/pdm_mic_capture.sv | 204 ++++++++++++++++++++
 tb/tb_pdm_mic_capture.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_capture.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_mic_capture
//  Description : Drives a PDM microphone clock, synchronizes the returned
//                bitstream, decimates it with a box-car ones counter and, on
//                request, stores a fixed number of decimated samples through a
//                simple RAM write port.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i           system clock, all logic on its rising edge
//    rst_ni          asynchronous active-low reset
//    start_i         capture request (level or pulse), honoured only in IDLE
//    mic_data_i      PDM bitstream from the microphone (asynchronous)
//    mic_clk_o       microphone clock, clk_i / (2*MIC_HALF)
//    mic_lrsel_o     channel select, tied low (data valid on mic_clk rise)
//    sample_o        last completed decimated sample (ones count)
//    sample_valid_o  one-cycle pulse when sample_o updates
//    wr_en_o         RAM write strobe
//    wr_addr_o       RAM write address (holds between writes)
//    wr_data_o       RAM write data, always equal to sample_o
//    busy_o          high while a capture is in progress
//    done_o          one-cycle pulse after the final write of a capture
// ============================================================================
module pdm_mic_capture #(
    parameter int MIC_HALF = 8,
    parameter int DECIM    = 195,
    parameter int LENGTH   = 3680
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        mic_data_i,
    output logic        mic_clk_o,
    output logic        mic_lrsel_o,
    output logic [7:0]  sample_o,
    output logic        sample_valid_o,
    output logic        wr_en_o,
    output logic [11:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int               c_div_w    = (MIC_HALF > 1) ? $clog2(MIC_HALF) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(MIC_HALF - 1);
    localparam logic [7:0]       c_win_last = 8'(DECIM - 1);
    localparam logic [11:0]      c_idx_last = 12'(LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [c_div_w-1:0] div_q,  div_d;
    logic               mic_clk_q, mic_clk_d;
    logic               sync1_q, sync2_q;
    logic [7:0]         win_q,  win_d;
    logic [7:0]         acc_q,  acc_d;
    logic [7:0]         sample_q, sample_d;
    logic               sample_valid_q, sample_valid_d;

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    state_t             state_q;
    logic [11:0]        index_q;
    logic               wr_en_q;
    logic [11:0]        wr_addr_q;
    logic               busy_q;
    logic               done_q;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_mic_tick;
    logic               w_strobe;
    logic               w_win_end;
    logic               w_restart;
    logic [7:0]         w_acc_sum;

    assign w_mic_tick = (div_q == c_div_last);
    // Taking the bit as mic_clk falls gives the mic a full half-period after
    // its rising-edge data launch, plus the synchronizer latency.
    assign w_strobe   = w_mic_tick & mic_clk_q;
    assign w_win_end  = w_strobe & (win_q == c_win_last);
    assign w_restart  = (state_q == S_IDLE) & start_i;
    // Accumulator plus the bit arriving with the current strobe; at most
    // DECIM <= 255, so eight bits never overflow.
    assign w_acc_sum  = acc_q + {7'b0, sync2_q};

    always_comb begin
        div_d          = w_mic_tick ? '0 : div_q + 1'b1;
        mic_clk_d      = w_mic_tick ? ~mic_clk_q : mic_clk_q;

        win_d          = win_q;
        acc_d          = acc_q;
        if (w_restart) begin
            // A new capture starts with a fresh, fully populated window.
            win_d = '0;
            acc_d = '0;
        end else if (w_strobe) begin
            if (w_win_end) begin
                win_d = '0;
                acc_d = '0;
            end else begin
                win_d = win_q + 8'd1;
                acc_d = w_acc_sum;
            end
        end

        sample_d       = w_win_end ? w_acc_sum : sample_q;
        sample_valid_d = w_win_end;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q          <= '0;
            mic_clk_q      <= 1'b0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            win_q          <= '0;
            acc_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            div_q          <= div_d;
            mic_clk_q      <= mic_clk_d;
            sync1_q        <= mic_data_i;
            sync2_q        <= sync1_q;
            win_q          <= win_d;
            acc_q          <= acc_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Capture FSM. The write is registered on the same edge that registers the
    // new sample, so wr_en_o and sample_valid_o are coincident and wr_data_o
    // (a mirror of sample_o) already carries the new value.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_CAPTURE;
                        index_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (w_win_end) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= index_q;
                        index_q   <= index_q + 12'd1;
                        if (index_q == c_idx_last) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // busy drops together with the done pulse.
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mic_clk_o      = mic_clk_q;
    assign mic_lrsel_o    = 1'b0;
    assign sample_o       = sample_q;
    assign sample_valid_o = sample_valid_q;
    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = sample_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_mic_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pdm_mic_capture
//  Description : Self-checking bench for pdm_mic_capture with LENGTH=4.
//                Expected RAM writes are queued when a capture is launched and
//                compared by a monitor as the writes appear.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pdm_mic_capture;

    localparam int c_len    = 4;
    localparam int c_period = 3120;   // 195 bits * 16 clk per bit

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mic_lvl;
    logic        alt_en;
    logic        alt_bit;
    logic        mic_data;
    logic        mic_clk_o;
    logic        mic_lrsel_o;
    logic [7:0]  sample_o;
    logic        sample_valid_o;
    logic        wr_en_o;
    logic [11:0] wr_addr_o;
    logic [7:0]  wr_data_o;
    logic        busy_o;
    logic        done_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int sb_a;
    int sb_d;
    int exp_addr_q[$];
    int exp_data_q[$];

    assign mic_data = alt_en ? alt_bit : mic_lvl;

    pdm_mic_capture #(
        .MIC_HALF (8),
        .DECIM    (195),
        .LENGTH   (c_len)
    ) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .mic_data_i     (mic_data),
        .mic_clk_o      (mic_clk_o),
        .mic_lrsel_o    (mic_lrsel_o),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Alternating pattern: a new bit on every microphone clock rise.
    always @(posedge mic_clk_o) alt_bit <= ~alt_bit;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Write scoreboard and done counter.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_o) done_cnt++;
            if (wr_en_o) begin
                wr_cnt++;
                if (exp_addr_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    sb_a = exp_addr_q.pop_front();
                    sb_d = exp_data_q.pop_front();
                    check("wr_addr", int'(wr_addr_o), sb_a);
                    check("wr_data", int'(wr_data_o), sb_d);
                end
            end
        end
    end

    task automatic push_capture(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(i);
            exp_data_q.push_back(195);
        end
    endtask

    task automatic wait_valid(input string tag, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 4000 && at < 0) begin
            @(negedge clk);
            n++;
            if (sample_valid_o) at = cyc;
        end
        if (at < 0) check({tag, "_valid_timeout"}, 0, 1);
    endtask

    task automatic wait_wr(input string tag, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 4000 && at < 0) begin
            @(negedge clk);
            n++;
            if (wr_en_o) at = cyc;
        end
        if (at < 0) check({tag, "_wr_timeout"}, 0, 1);
    endtask

    initial begin
        #(100000 * 40);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int t1;
        int s1;
        int s2;
        int w[8];
        int d0;

        rst_n   = 1'b0;
        start   = 1'b0;
        mic_lvl = 1'b1;
        alt_en  = 1'b0;
        alt_bit = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_mic_clk", int'(mic_clk_o), 0);
        check("rst_lrsel", int'(mic_lrsel_o), 0);
        check("rst_sample", int'(sample_o), 0);
        check("rst_valid", int'(sample_valid_o), 0);
        check("rst_wr_en", int'(wr_en_o), 0);
        check("rst_wr_addr", int'(wr_addr_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);

        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mic_clk_o && n < 40);
        check("mic_clk_first_rise", n, 8);

        // ---------------- constant ones, no start ----------------
        wait_valid("ones0", t0);
        check("ones_sample0", int'(sample_o), 195);
        check("ones_wr_data_mirror", int'(wr_data_o), 195);
        wait_valid("ones1", t1);
        check("ones_sample1", int'(sample_o), 195);
        check("ones_period", t1 - t0, c_period);
        @(negedge clk);
        check("valid_one_cycle", int'(sample_valid_o), 0);
        check("idle_no_write", wr_cnt, 0);

        // ---------------- constant zeros ----------------
        mic_lvl = 1'b0;
        wait_valid("zeros_mixed", t0);
        wait_valid("zeros", t1);
        check("zeros_sample", int'(sample_o), 0);

        // ---------------- alternating bits ----------------
        alt_en = 1'b1;
        wait_valid("alt_mixed", t0);
        wait_valid("alt1", t0);
        s1 = int'(sample_o);
        wait_valid("alt2", t1);
        s2 = int'(sample_o);
        check("alt_s1_in_range", (s1 == 97 || s1 == 98) ? 1 : 0, 1);
        check("alt_s2_in_range", (s2 == 97 || s2 == 98) ? 1 : 0, 1);
        check("alt_pair_sum", s1 + s2, 195);
        alt_en  = 1'b0;
        mic_lvl = 1'b1;
        repeat (4) @(negedge clk);

        // ---------------- single capture, extra start mid-way ----------------
        d0 = done_cnt;
        push_capture(c_len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cap_busy_high", int'(busy_o), 1);
        wait_wr("cap0", w[0]);
        wait_wr("cap1", w[1]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_wr("cap2", w[2]);
        wait_wr("cap3", w[3]);
        check("cap_gap01", w[1] - w[0], c_period);
        check("cap_gap12", w[2] - w[1], c_period);
        check("cap_gap23", w[3] - w[2], c_period);
        check("cap_busy_at_last_wr", int'(busy_o), 1);
        @(negedge clk);
        check("cap_done_pulse", int'(done_o), 1);
        check("cap_busy_fall", int'(busy_o), 0);
        @(negedge clk);
        check("cap_done_one_cycle", int'(done_o), 0);
        check("cap_done_count", done_cnt - d0, 1);
        check("cap_sb_empty", exp_addr_q.size(), 0);

        // ---------------- reset between write 2 and write 3 ----------------
        push_capture(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_wr("rst_cap0", w[0]);
        wait_wr("rst_cap1", w[1]);
        repeat (100) @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        check("abort_mic_clk", int'(mic_clk_o), 0);
        check("abort_sample", int'(sample_o), 0);
        check("abort_valid", int'(sample_valid_o), 0);
        check("abort_wr_en", int'(wr_en_o), 0);
        check("abort_wr_addr", int'(wr_addr_o), 0);
        check("abort_wr_data", int'(wr_data_o), 0);
        check("abort_busy", int'(busy_o), 0);
        check("abort_done", int'(done_o), 0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3200) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_busy", int'(busy_o), 0);
        check("abort_sb_empty", exp_addr_q.size(), 0);

        // ---------------- start held high: back-to-back captures ----------------
        d0 = done_cnt;
        push_capture(c_len);
        push_capture(c_len);
        start = 1'b1;
        for (int k = 0; k < 2 * c_len; k++) begin
            wait_wr("held", w[k]);
        end
        @(negedge clk);
        start = 1'b0;
        check("held_final_done", int'(done_o), 1);
        repeat (50) @(negedge clk);
        check("held_idle_busy", int'(busy_o), 0);
        check("held_done_count", done_cnt - d0, 2);
        check("held_sb_empty", exp_addr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
